// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared FSM state type and default width for the divider
package iterative_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - request/result bundle between a divider client and the divider
interface iterative_divider_if
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             Signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             DivZero;

  modport master (
    output start, Signed, dividend, divisor,
    input  busy, done, quotient, remainder, DivZero
  );

  modport slave (
    input  start, Signed, dividend, divisor,
    output busy, done, quotient, remainder, DivZero
  );

endinterface

// File: rtl/iterative_divider_div_step.sv
// rtl/iterative_divider_div_step.sv - one restoring shift-subtract step on unsigned magnitudes
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_div};

  // i_rem < i_div keeps w_shift below 2*i_div, so the top bit of the
  // difference is set exactly when the trial subtraction underflows.
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle signed/unsigned restoring divider, one quotient bit per clock
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  iterative_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic             w_busy;
  logic             w_done;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operands are reduced to magnitudes at capture; the most-negative value
  // maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign w_a_neg    = bus.Signed & bus.dividend[WIDTH-1];
  assign w_b_neg    = bus.Signed & bus.divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_b_mag    = w_b_neg ? -bus.divisor : bus.divisor;
  assign w_div_zero = (bus.divisor == '0);
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_last     = (r_state == CALC) && (r_count == CW'(1));

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  // r_quo shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign w_q_mag = {r_quo[WIDTH-2:0], w_qbit};
  assign w_q_fix = r_neg_q ? -w_q_mag : w_q_mag;
  assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = w_div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_count == CW'(1)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      CALC: w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_count <= CW'(WIDTH);
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_div   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_div_zero) begin
        r_q  <= '1;
        r_r  <= bus.dividend;
        r_dz <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_count <= r_count - CW'(1);
      r_rem   <= w_rem_next;
      r_quo   <= w_q_mag;
      if (w_last) begin
        r_q  <= w_q_fix;
        r_r  <= w_r_fix;
        r_dz <= 1'b0;
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.quotient  = r_q;
  assign bus.remainder = r_r;
  assign bus.DivZero   = r_dz;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - scoreboard bench for iterative_divider with randomized operands
module tb_iterative_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [W-1:0] hq, hr;
  logic         hdz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iterative_divider_if #(.WIDTH(W)) bus ();

  iterative_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp_v);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, in 64 bits then cut to W.
  function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv;
    longint unsigned ua, ub;
    e.at = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.q = W'(sa / sbv); e.r = W'(sa % sbv); e.dz = 1'b0;
    end else begin
      ua = longint'(a); ub = longint'(b);
      e.q = W'(ua / ub); e.r = W'(ua % ub); e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hq = '0; hr = '0; hdz = 1'b0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pending operation", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", bus.quotient, mon_e.q);
        check("remainder", bus.remainder, mon_e.r);
        check("divzero", W'(bus.DivZero), W'(mon_e.dz));
        check("done_cycle", W'(cyc), W'(mon_e.at));
        hq = mon_e.q; hr = mon_e.r; hdz = mon_e.dz;
      end
    end else begin
      check("hold_quotient", bus.quotient, hq);
      check("hold_remainder", bus.remainder, hr);
      check("hold_divzero", W'(bus.DivZero), W'(hdz));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1, want busy=0 within 200 cycles");
    end
  endtask

  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    wait_idle();
    bus.start = 1'b1; bus.Signed = s; bus.dividend = a; bus.divisor = b;
    sb.push_back('{q, r, dz, cyc + 1 + ((b == '0) ? 0 : W)});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic issue_model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    m = model(s, a, b);
    issue(s, a, b, m.q, m.r, m.dz);
  endtask

  initial begin
    bit s;
    logic [W-1:0] a, b;
    int n;
    bus.start = 1'b0; bus.Signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_divzero", W'(bus.DivZero), '0);
    // reset wins over a simultaneous start
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd0;
    @(posedge clk); #1;
    check("rst_over_start", W'(bus.busy), '0);
    bus.start = 1'b0;
    rst = 1'b0;

    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // A second start mid-calculation must not disturb the running op.
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.Signed = 1'b0; bus.dividend = 32'd7; bus.divisor = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;

    // Reset mid-calculation abandons the op; the monitor flags any done for it.
    wait_idle();
    bus.start = 1'b1; bus.Signed = 1'b0; bus.dividend = 32'd12345; bus.divisor = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_quotient", bus.quotient, '0);
    check("midrst_remainder", bus.remainder, '0);
    check("midrst_divzero", W'(bus.DivZero), '0);
    rst = 1'b0;
    repeat (W + 5) @(posedge clk);
    #1;
    check("midrst_idle", W'(bus.busy), '0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'h8000_0000;
        default: b = 32'($urandom);
      endcase
      issue_model(s, a, b);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL provide port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1: request a division; sampled only in IDLE.
REQ-005 SHALL provide port Signed  input  1: 1 = two's-complement (DIV), 0 = unsigned (DIVU); captured with start.
REQ-006 SHALL provide port dividend  input  WIDTH: numerator; captured with start.
REQ-007 SHALL provide port divisor  input  WIDTH: denominator; captured with start.
REQ-008 SHALL provide port busy  output  1: high in CALC and DONE.
REQ-009 SHALL provide port done  output  1: one-cycle pulse; results valid in that cycle.
REQ-010 SHALL provide port quotient  output  WIDTH: quotient (LO).
REQ-011 SHALL provide port remainder  output  WIDTH: remainder (HI).
REQ-012 SHALL provide port DivZero  output  1: divisor was zero for the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE + start=1 at edge k SHALL capture operands, load step counter = WIDTH, and enter CALC (divisor != 0) or DONE (divisor == 0).
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle on operand magnitudes; after WIDTH steps, enter DONE.
REQ-016 Nonzero-divisor latency: start sampled at edge k -> done=1 in the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-017 Zero-divisor latency: start sampled at edge k -> done=1 in the cycle between edges k and k+1.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 Signed=1: quotient negated when operand signs differ; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-021 Signed=1, dividend = most-negative, divisor = -1: quotient = most-negative, remainder = 0 (WIDTH-bit truncation; no trap).
REQ-022 Zero divisor: quotient = all ones, remainder = dividend (unmodified), DivZero = 1.
REQ-023 quotient, remainder and DivZero SHALL update only on entry to DONE and hold until the next DONE.
REQ-024 start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operations).

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, DivZero=0, counter=0.
REQ-026 rst mid-CALC SHALL abandon the operation; no done pulse for it.
REQ-027 rst has priority over start when both are high at the same edge.

Structure
REQ-028 Shared package SHALL hold the FSM state type (IDLE/CALC/DONE) and default WIDTH constant.
REQ-029 One combinational sub-module div_step SHALL compute one restoring step (partial remainder, divisor -> next remainder, quotient bit); iterated in time, not replicated.
REQ-030 Sign correction (magnitude in, negate out) SHALL sit in iterative_divider, outside div_step.

Verification
REQ-031 Unsigned 100 / 7 -> quotient 14, remainder 2, DivZero 0, done exactly 32 cycles after start edge.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-034 Unsigned 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, DivZero 1, done in the cycle after start edge.
REQ-035 start pulsed again at CALC step 10 -> ignored, first result unaffected; rst at step 10 -> IDLE, outputs 0, no done; fresh 0xFFFFFFFF / 1 unsigned afterwards -> quotient 0xFFFFFFFF, remainder 0.
